mdu_iter: RTL and testbench



---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_mul_pipe.sv | 28 ++
 rtl/mdu_iter.sv | 171 +++++++++++++++++
 tb/tb_mdu_iter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 op codes, FSM states, op helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  // Signed divide/remainder: operands are treated as two's complement
  function automatic logic is_signed_div(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Any of the four divider ops
  function automatic logic is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Remainder ops return the remainder instead of the quotient
  function automatic logic is_rem(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_mul_pipe.sv
// DEPTH-stage registered multiplier on pre-extended operands; stalls (holds) when en is low.
module mdu_mul_pipe #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] prod
);

  logic [W-1:0] stage [DEPTH];

  // Stage 0 captures the product, later stages shift it towards the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= a * b;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign prod = stage[DEPTH-1];

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle RV32M/RV64M multiply-divide unit: pipelined multiplier, radix-2 restoring divider.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [XLEN-1:0]  i_x,
  input  logic [XLEN-1:0]  i_y,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_res,
  output logic [TAG_W-1:0] o_tag
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] DIV_INIT = CW'(XLEN - 1);
  localparam logic [CW-1:0] MUL_INIT = CW'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state;
  op_e              op;
  logic [CW-1:0]    cnt;
  logic [XLEN-1:0]  rem, quo, dvs, res;
  logic             neg_q, neg_r, valid;
  logic [TAG_W-1:0] tag;

  op_e              in_op;
  logic             x_neg, y_neg, div_zero, div_ovf, x_sext, y_sext, mul_en;
  logic [XLEN-1:0]  x_mag, y_mag, rem_step, quo_step, quo_fix, rem_fix, mul_res;
  logic [XLEN:0]    rem_shift, diff;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;

  assign in_op   = op_e'(i_op);
  assign o_ready = (state == ST_IDLE);
  assign o_valid = valid;
  assign o_tag   = tag;
  assign mul_en  = (o_ready && i_valid && !is_div(in_op)) || (state == ST_MUL);

  // Operand preparation at accept plus one restoring-division step on the held registers
  always_comb begin
    x_neg    = is_signed_div(in_op) && i_x[XLEN-1];
    y_neg    = is_signed_div(in_op) && i_y[XLEN-1];
    x_mag    = x_neg ? -i_x : i_x;
    y_mag    = y_neg ? -i_y : i_y;
    div_zero = (i_y == '0);
    div_ovf  = is_signed_div(in_op) && (i_x == MIN_NEG) && (i_y == '1);
    x_sext   = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && i_x[XLEN-1];
    y_sext   = (in_op == OP_MULH) && i_y[XLEN-1];
    mul_a    = {{XLEN{x_sext}}, i_x};
    mul_b    = {{XLEN{y_sext}}, i_y};
    // Shift the next dividend bit into the partial remainder and try subtracting the divisor
    rem_shift = {rem, quo[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs};
    if (!diff[XLEN]) begin
      rem_step = diff[XLEN-1:0];
      quo_step = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_step = rem_shift[XLEN-1:0];
      quo_step = {quo[XLEN-2:0], 1'b0};
    end
    quo_fix = neg_q ? -quo : quo;
    rem_fix = neg_r ? -rem : rem;
    mul_res = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Multiplier results come straight from the held pipe output; divider results from res
  assign o_res = is_div(op) ? res : mul_res;

  mdu_mul_pipe #(
    .W     (2*XLEN),
    .DEPTH (MUL_CYCLES)
  ) u_mul (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (mul_en),
    .a     (mul_a),
    .b     (mul_b),
    .prod  (prod)
  );

  // Control FSM with registered result valid; flush beats accept and handoff
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      op    <= OP_MUL;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      res   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      valid <= 1'b0;
      tag   <= '0;
    end else if (i_flush) begin
      state <= ST_IDLE;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            op  <= in_op;
            tag <= i_tag;
            if (!is_div(in_op)) begin
              if (MUL_CYCLES == 1) begin
                state <= ST_DONE;
                valid <= 1'b1;
              end else begin
                state <= ST_MUL;
                cnt   <= MUL_INIT;
              end
            end else if (div_zero) begin
              res   <= is_rem(in_op) ? i_x : '1;
              state <= ST_DONE;
              valid <= 1'b1;
            end else if (div_ovf) begin
              res   <= is_rem(in_op) ? '0 : i_x;
              state <= ST_DONE;
              valid <= 1'b1;
            end else begin
              rem   <= '0;
              quo   <= x_mag;
              dvs   <= y_mag;
              neg_q <= x_neg ^ y_neg;
              neg_r <= x_neg;
              cnt   <= DIV_INIT;
              state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_FIX: begin
          res   <= is_rem(op) ? rem_fix : quo_fix;
          state <= ST_DONE;
          valid <= 1'b1;
        end
        ST_DONE: begin
          if (i_ready) begin
            state <= ST_IDLE;
            valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: XLEN=32 and XLEN=64 instances, hand-computed vectors.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ready_in = 1'b0;
  logic        v32 = 1'b0, v64 = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [63:0] x = '0, y = '0;
  logic [4:0]  tag = '0;

  logic        rdy32, val32, rdy64, val64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [4:0]  tag32, tag64;

  int n_tests = 0;
  int n_fail  = 0;
  bit sel64   = 1'b0;

  logic        cur_valid, cur_ready;
  logic [63:0] cur_res;
  logic [4:0]  cur_tag;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .MUL_CYCLES(2), .TAG_W(5)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v32), .o_ready(rdy32),
    .i_op(op), .i_x(x[31:0]), .i_y(y[31:0]), .i_tag(tag),
    .o_valid(val32), .i_ready(ready_in), .o_res(res32), .o_tag(tag32)
  );

  mdu_iter #(.XLEN(64), .MUL_CYCLES(2), .TAG_W(5)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v64), .o_ready(rdy64),
    .i_op(op), .i_x(x), .i_y(y), .i_tag(tag),
    .o_valid(val64), .i_ready(ready_in), .o_res(res64), .o_tag(tag64)
  );

  always_comb begin
    cur_valid = sel64 ? val64 : val32;
    cur_ready = sel64 ? rdy64 : rdy32;
    cur_res   = sel64 ? res64 : {32'h0, res32};
    cur_tag   = sel64 ? tag64 : tag32;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One transaction: accept, measure latency, hold back-pressure, hand off
  task automatic run_op(input bit w64, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] t, input logic [63:0] exp,
                        input int lat, input int hold, input string name);
    int n;
    sel64 = w64;
    check({name, ".ready"}, {63'h0, cur_ready}, 64'h1);
    op = o; x = a; y = b; tag = t;
    if (w64) v64 = 1'b1; else v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    x = ~a; y = ~b;  // operands must not be re-read after accept
    n = 0;
    while (!cur_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, ".lat"}, 64'(n + 1), 64'(lat));
    check({name, ".res"}, cur_res, exp);
    check({name, ".tag"}, {59'h0, cur_tag}, {59'h0, t});
    $display("[TB] %s op=%b x=%h y=%h tag=%0d -> res=%h lat=%0d", name, o, a, b, t, cur_res, n + 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, ".hold_valid"}, {63'h0, cur_valid}, 64'h1);
      check({name, ".hold_res"}, cur_res, exp);
      check({name, ".hold_tag"}, {59'h0, cur_tag}, {59'h0, t});
      check({name, ".hold_ready"}, {63'h0, cur_ready}, 64'h0);
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    check({name, ".after_valid"}, {63'h0, cur_valid}, 64'h0);
    check({name, ".after_ready"}, {63'h0, cur_ready}, 64'h1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    vecs = '{
      '{3'b001, 64'h80000000, 64'h80000000, 64'h40000000, 2,  "mulh"},
      '{3'b010, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 2,  "mulhsu"},
      '{3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 2,  "mulhu"},
      '{3'b000, 64'h12345678, 64'h00000010, 64'h23456780, 2,  "mul"},
      '{3'b100, 64'hFFFFFFF9, 64'h00000002, 64'hFFFFFFFD, 34, "div_m7_2"},
      '{3'b110, 64'hFFFFFFF9, 64'h00000002, 64'hFFFFFFFF, 34, "rem_m7_2"},
      '{3'b101, 64'd100,      64'd7,        64'd14,       34, "divu_100_7"},
      '{3'b111, 64'd100,      64'd7,        64'd2,        34, "remu_100_7"},
      '{3'b100, 64'd7,        64'hFFFFFFFE, 64'hFFFFFFFD, 34, "div_7_m2"},
      '{3'b110, 64'd7,        64'hFFFFFFFE, 64'd1,        34, "rem_7_m2"},
      '{3'b101, 64'd5,        64'd0,        64'hFFFFFFFF, 1,  "divu_by0"},
      '{3'b110, 64'd5,        64'd0,        64'd5,        1,  "rem_by0"},
      '{3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1,  "div_ovf"},
      '{3'b110, 64'h80000000, 64'hFFFFFFFF, 64'd0,        1,  "rem_ovf"}
    };

    // Reset state while i_rst_n is low
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", {63'h0, val32}, 64'h0);
    check("rst.ready", {63'h0, rdy32}, 64'h1);
    check("rst.res", {32'h0, res32}, 64'h0);
    check("rst.tag", {59'h0, tag32}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_op(1'b0, vecs[i].op, vecs[i].x, vecs[i].y, 5'(i + 3), vecs[i].exp, vecs[i].lat, 0, vecs[i].name);

    // Back-pressure: result held for 5 cycles
    run_op(1'b0, 3'b101, 64'd100, 64'd7, 5'd21, 64'd14, 34, 5, "bp_divu");

    // Flush mid-divide: accepted in cycle T, flush driven in cycle T+10
    sel64 = 1'b0;
    op = 3'b100; x = 64'hFFFFFFF9; y = 64'd2; tag = 5'd9; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush.busy_ready", {63'h0, rdy32}, 64'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.ready", {63'h0, rdy32}, 64'h1);
    check("flush.valid", {63'h0, val32}, 64'h0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (val32) seen = 1'b1;
    end
    check("flush.never_valid", {63'h0, seen}, 64'h0);
    $display("[TB] flush DIV tag=9 -> ready=%b valid_seen=%b", rdy32, seen);
    run_op(1'b0, 3'b101, 64'd100, 64'd7, 5'd22, 64'd14, 34, 0, "post_flush_divu");

    // Asynchronous reset mid-divide
    op = 3'b100; x = 64'd1000; y = 64'd3; tag = 5'd17; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", {63'h0, val32}, 64'h0);
    check("arst.ready", {63'h0, rdy32}, 64'h1);
    check("arst.tag", {59'h0, tag32}, 64'h0);
    $display("[TB] async reset mid-DIV -> valid=%b ready=%b", val32, rdy32);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 3'b100, 64'd1000, 64'd3, 5'd18, 64'd333, 34, 0, "post_rst_div");

    // 64-bit instance
    run_op(1'b1, 3'b101, 64'hFFFFFFFFFFFFFFFF, 64'd3, 5'd30, 64'h5555555555555555, 66, 0, "divu64");
    run_op(1'b1, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd31, 64'hFFFFFFFFFFFFFFFE, 2, 0, "mulhu64");
    run_op(1'b1, 3'b110, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd1, 64'd0, 1, 0, "rem64_ovf");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
